// File: rtl/ds2411_id_check.sv
// DS2411 serial-number check: drives the reader, CRC-8 checks the ROM code, retries, publishes the ID.
// Build option: define DS2411_FAMILY_CHECK_EN to also require family code 8'h01.
module ds2411_id_check #(
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned GO_HOLD        = 250,
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter int unsigned AUTO_START     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        rd_go,
  input  logic [63:0] rd_result,
  input  logic        rd_done,
  input  logic        rd_error,
  input  logic        rd_working,
  output logic        busy,
  output logic        id_valid,
  output logic        id_fail,
  output logic [1:0]  fail_code,
  output logic [3:0]  attempts,
  output logic [47:0] serial_number,
  output logic [7:0]  family_code
);

  localparam int unsigned CRC_BITS = 56;
  localparam int unsigned HOLD_MAX = (GO_HOLD > CRC_BITS) ? GO_HOLD : CRC_BITS;
  localparam int unsigned CNT_MAX  = (TIMEOUT_CYCLES > HOLD_MAX) ? TIMEOUT_CYCLES : HOLD_MAX;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_NOPRES  = 2'd1;
  localparam logic [1:0] FC_CRC     = 2'd2;
  localparam logic [1:0] FC_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_CRC,
    ST_CHECK,
    ST_RETRY
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               auto_pend, auto_nxt;
  logic [1:0]         pend_code, pend_nxt;
  logic [63:0]        captured, captured_nxt;
  logic [7:0]         crc, crc_nxt;
  logic               go_nxt, busy_nxt, valid_nxt, fail_nxt;
  logic [1:0]         fc_nxt;
  logic [3:0]         att_nxt;
  logic [47:0]        serial_nxt;
  logic [7:0]         family_nxt;
  logic               crc_fb;
  logic               id_pass;

  assign crc_fb = crc[0] ^ captured[cnt[5:0]];

  // An all-zero code satisfies the CRC but means the bus is stuck low.
`ifdef DS2411_FAMILY_CHECK_EN
  assign id_pass = (crc == captured[63:56]) && (captured != 64'h0) && (captured[7:0] == 8'h01);
`else
  assign id_pass = (crc == captured[63:56]) && (captured != 64'h0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      auto_pend     <= (AUTO_START != 0);
      pend_code     <= FC_NONE;
      captured      <= '0;
      crc           <= '0;
      rd_go         <= 1'b0;
      busy          <= 1'b0;
      id_valid      <= 1'b0;
      id_fail       <= 1'b0;
      fail_code     <= FC_NONE;
      attempts      <= '0;
      serial_number <= '0;
      family_code   <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      auto_pend     <= auto_nxt;
      pend_code     <= pend_nxt;
      captured      <= captured_nxt;
      crc           <= crc_nxt;
      rd_go         <= go_nxt;
      busy          <= busy_nxt;
      id_valid      <= valid_nxt;
      id_fail       <= fail_nxt;
      fail_code     <= fc_nxt;
      attempts      <= att_nxt;
      serial_number <= serial_nxt;
      family_code   <= family_nxt;
    end
  end

  // Next-state and registered-output logic; rd_go is high exactly while the next state is REQ.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    auto_nxt     = auto_pend;
    pend_nxt     = pend_code;
    captured_nxt = captured;
    crc_nxt      = crc;
    go_nxt       = 1'b0;
    busy_nxt     = busy;
    valid_nxt    = id_valid;
    fail_nxt     = id_fail;
    fc_nxt       = fail_code;
    att_nxt      = attempts;
    serial_nxt   = serial_number;
    family_nxt   = family_code;

    case (state)
      ST_IDLE: begin
        if (start || auto_pend) begin
          auto_nxt  = 1'b0;
          valid_nxt = 1'b0;
          fail_nxt  = 1'b0;
          fc_nxt    = FC_NONE;
          att_nxt   = 4'd1;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
          go_nxt    = 1'b1;
          state_nxt = ST_REQ;
        end
      end

      // A reader that is already working counts as an acknowledge.
      ST_REQ: begin
        if (rd_working) begin
          cnt_nxt   = '0;
          state_nxt = ST_WAIT;
        end else if (cnt == CNT_W'(GO_HOLD - 1)) begin
          pend_nxt  = FC_TIMEOUT;
          state_nxt = ST_RETRY;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          go_nxt  = 1'b1;
        end
      end

      ST_WAIT: begin
        if (!rd_working) begin
          if (rd_done && !rd_error) begin
            captured_nxt = rd_result;
            crc_nxt      = 8'h00;
            cnt_nxt      = '0;
            state_nxt    = ST_CRC;
          end else begin
            pend_nxt  = FC_NOPRES;
            state_nxt = ST_RETRY;
          end
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          pend_nxt  = FC_TIMEOUT;
          state_nxt = ST_RETRY;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      // Dallas CRC-8, reflected polynomial 0x8C, one bit per clock, LSB first.
      ST_CRC: begin
        crc_nxt = {1'b0, crc[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);
        if (cnt == CNT_W'(CRC_BITS - 1)) begin
          state_nxt = ST_CHECK;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_CHECK: begin
        if (id_pass) begin
          serial_nxt = captured[55:8];
          family_nxt = captured[7:0];
          valid_nxt  = 1'b1;
          fc_nxt     = FC_NONE;
          busy_nxt   = 1'b0;
          state_nxt  = ST_IDLE;
        end else begin
          pend_nxt  = FC_CRC;
          state_nxt = ST_RETRY;
        end
      end

      ST_RETRY: begin
        fc_nxt = pend_code;
        if (attempts < 4'(MAX_ATTEMPTS)) begin
          att_nxt   = attempts + 4'd1;
          cnt_nxt   = '0;
          go_nxt    = 1'b1;
          state_nxt = ST_REQ;
        end else begin
          fail_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ds2411_id_check.sv
// Randomized self-checking bench for ds2411_id_check with a scripted DS2411 reader model.
module tb_ds2411_id_check;

  localparam int unsigned MAX_ATT  = 3;
  localparam int unsigned GO_HOLD  = 250;
  localparam int unsigned TMO      = 3000;
  localparam int unsigned CRC_LAT  = 58;
  localparam int          BOUND    = 3 * (TMO + 400) + 500;
  localparam int M_GOOD = 0, M_ERR = 1, M_NORESP = 2, M_HANG = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rd_go;
  logic [63:0] rd_result = '0;
  logic        rd_done = 1'b0;
  logic        rd_error = 1'b0;
  logic        rd_working = 1'b0;
  logic        busy, id_valid, id_fail;
  logic [1:0]  fail_code;
  logic [3:0]  attempts;
  logic [47:0] serial_number;
  logic [7:0]  family_code;

  ds2411_id_check #(
    .MAX_ATTEMPTS(MAX_ATT), .GO_HOLD(GO_HOLD), .TIMEOUT_CYCLES(TMO), .AUTO_START(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rd_go(rd_go), .rd_result(rd_result),
    .rd_done(rd_done), .rd_error(rd_error), .rd_working(rd_working), .busy(busy),
    .id_valid(id_valid), .id_fail(id_fail), .fail_code(fail_code), .attempts(attempts),
    .serial_number(serial_number), .family_code(family_code)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference CRC straight from the Dallas definition.
  function automatic logic [7:0] crc8(input logic [63:0] d, input int nbits);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 8'h8C;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // A good ROM code leaves a zero residue when the CRC byte is run through too.
  function automatic bit code_ok(input logic [63:0] c);
    bit ok;
    ok = (crc8(c, 64) == 8'h00) && (c != 64'h0);
`ifdef DS2411_FAMILY_CHECK_EN
    if (c[7:0] != 8'h01) ok = 1'b0;
`endif
    return ok;
  endfunction

  function automatic logic [63:0] mk_code(input logic [7:0] fam, input logic [47:0] ser);
    logic [63:0] d;
    d = {8'h00, ser, fam};
    d[63:56] = crc8(d, 56);
    return d;
  endfunction

  // Reader script and observation state.
  int          m_mode [3];
  logic [63:0] m_code [3];
  int          g_base = 0;
  int          go_cnt = 0, go_run = 0, go_len = 0;
  logic        go_prev = 1'b0;
  int          m_st = 0, m_cnt = 0, m_idx = 0;
  longint      cyc = 0, done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reader model: acknowledges go after a delay, finishes later, scrambles result after completion.
  always @(negedge clk) begin
    if (rd_go && !go_prev) go_cnt++;
    if (rd_go) go_run++;
    else if (go_prev) begin go_len = go_run; go_run = 0; end
    go_prev = rd_go;
    if (reset) begin
      m_st = 0; rd_working = 1'b0; rd_done = 1'b0; rd_error = 1'b0;
    end else begin
      case (m_st)
        0: if (rd_go) begin
          m_idx = go_cnt - g_base - 1;
          if (m_idx < 0) m_idx = 0;
          if (m_idx > 2) m_idx = 2;
          rd_done = 1'b0; rd_error = 1'b0;
          m_cnt = $urandom_range(1, 20);
          m_st = (m_mode[m_idx] == M_NORESP) ? 3 : 1;
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin rd_working = 1'b1; m_cnt = $urandom_range(10, 200); m_st = 2; end
        end
        2: if (m_mode[m_idx] != M_HANG) begin
          m_cnt--;
          if (m_cnt == 0) begin
            rd_working = 1'b0;
            if (m_mode[m_idx] == M_ERR) rd_error = 1'b1;
            else begin rd_done = 1'b1; rd_result = m_code[m_idx]; end
            done_cyc = cyc;
            m_st = 4;
          end
        end
        3: if (!rd_go) m_st = 0;
        default: begin rd_result = {$urandom, $urandom}; m_st = 0; end
      endcase
    end
  end

  logic [47:0] exp_serial = '0;
  logic [7:0]  exp_family = '0;

  task automatic set_all(input int mode, input logic [63:0] code);
    for (int a = 0; a < 3; a++) begin m_mode[a] = mode; m_code[a] = code; end
  endtask

  task automatic check_reset(input string nm);
    check({nm, ".rd_go"}, rd_go, 0);
    check({nm, ".busy"}, busy, 0);
    check({nm, ".valid"}, id_valid, 0);
    check({nm, ".fail"}, id_fail, 0);
    check({nm, ".fcode"}, fail_code, 0);
    check({nm, ".att"}, attempts, 0);
    check({nm, ".serial"}, serial_number, 0);
    check({nm, ".family"}, family_code, 0);
  endtask

  // Runs one sequence (started by pulse or already auto-started) and checks the outcome.
  task automatic run_seq(input string nm, input bit pulse, input bit noisy);
    bit         e_valid;
    logic [1:0] e_fc;
    int         e_att, n;
    e_valid = 1'b0; e_fc = 2'd0; e_att = 0;
    for (int a = 0; a < int'(MAX_ATT); a++) begin
      e_att = a + 1;
      if (m_mode[a] == M_ERR) e_fc = 2'd1;
      else if (m_mode[a] == M_GOOD) begin
        if (code_ok(m_code[a])) begin
          e_valid = 1'b1; e_fc = 2'd0;
          exp_serial = m_code[a][55:8]; exp_family = m_code[a][7:0];
          break;
        end
        e_fc = 2'd2;
      end else e_fc = 2'd3;
    end
    g_base = go_cnt;
    if (pulse) begin start = 1'b1; @(negedge clk); start = 1'b0; end
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    check({nm, ".busy_rise"}, busy, 1);
    n = 0;
    while (busy && n < BOUND) begin
      start = noisy && (n % 40 == 7);
      @(negedge clk); n++;
    end
    start = 1'b0;
    check({nm, ".finished"}, busy, 0);
    check({nm, ".valid"}, id_valid, e_valid);
    check({nm, ".fail"}, id_fail, !e_valid);
    check({nm, ".fcode"}, fail_code, e_fc);
    check({nm, ".att"}, attempts, e_att);
    check({nm, ".serial"}, serial_number, exp_serial);
    check({nm, ".family"}, family_code, exp_family);
    check({nm, ".go_bursts"}, go_cnt - g_base, e_att);
    if (e_valid) check({nm, ".crc_latency"}, cyc - done_cyc, CRC_LAT);
  endtask

  localparam logic [63:0] EX_CODE = 64'hA200000001B81C02;

  initial begin
    logic [63:0] c, flip;
    longint d0;
    int b, n;

    set_all(M_GOOD, EX_CODE);
    repeat (3) @(negedge clk);
    check_reset("por");
    reset = 1'b0;
    run_seq("auto_example", 1'b0, 1'b0);

    run_seq("example", 1'b1, 1'b1);

    flip = EX_CODE;
    flip[20] = ~flip[20];
    set_all(M_GOOD, flip);
    run_seq("bit20", 1'b1, 1'b0);

    set_all(M_GOOD, EX_CODE);
    m_mode[0] = M_ERR;
    run_seq("err_then_good", 1'b1, 1'b0);

    set_all(M_NORESP, EX_CODE);
    run_seq("noresp", 1'b1, 1'b1);
    check("noresp.go_hold", go_len, GO_HOLD);

    set_all(M_GOOD, 64'h0);
    run_seq("zero_code", 1'b1, 1'b0);

    for (int t = 0; t < 8; t++) begin
      for (int a = 0; a < 3; a++) begin
        n = $urandom_range(0, 9);
        m_mode[a] = (n < 6) ? M_GOOD : (n < 8) ? M_ERR : M_NORESP;
        c = mk_code(($urandom_range(0, 1) != 0) ? 8'h01 : 8'($urandom),
                    {16'($urandom), 32'($urandom)});
        if ($urandom_range(0, 2) == 0) begin b = $urandom_range(0, 63); c[b] = ~c[b]; end
        m_code[a] = c;
      end
      run_seq($sformatf("rand%0d", t), 1'b1, (t % 2) == 1);
    end

    set_all(M_HANG, EX_CODE);
    run_seq("hang", 1'b1, 1'b0);

    // Reset clears the stuck reader; the auto-started sequence then runs.
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset("rst_after_hang");
    exp_serial = '0; exp_family = '0;
    set_all(M_GOOD, mk_code(8'h01, 48'h123456789ABC));
    reset = 1'b0;
    run_seq("auto_after_hang", 1'b0, 1'b0);

    // Reset ten cycles into the CRC phase.
    set_all(M_GOOD, mk_code(8'h01, 48'hCAFE0000BEEF));
    g_base = go_cnt;
    d0 = done_cyc;
    start = 1'b1; @(negedge clk); start = 1'b0;
    n = 0;
    while (done_cyc == d0 && n < BOUND) begin @(negedge clk); n++; end
    check("mid_crc.reader_done", done_cyc != d0, 1);
    repeat (11) @(negedge clk);
    check("mid_crc.busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset("mid_crc");
    exp_serial = '0; exp_family = '0;
    reset = 1'b0;
    run_seq("auto_after_abort", 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
